// File: rtl/rand_pkg.sv
`default_nettype none
//==============================================================================
// Package  : rand_pkg
// Desc     : Shared constants and state encoding for the random-source arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package rand_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

    // Feedback taps of the 16-bit maximal-length Fibonacci LFSR
    localparam int TAP_A = 3;
    localparam int TAP_B = 12;
    localparam int TAP_C = 14;
    localparam int TAP_D = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } rand_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr16_core.sv
`default_nettype none
//==============================================================================
// Module   : lfsr16_core
// Desc     : Free-running 16-bit Fibonacci LFSR with seed load; a zero seed
//            would lock the register, so it is replaced by LFSR_SEED.
// Revision : 1.0 - initial release
//==============================================================================
module lfsr16_core
    import rand_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic w_feedback;
    logic [15:0] w_seed_safe;

    assign w_feedback  = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];
    assign w_seed_safe = (seed == 16'h0000) ? LFSR_SEED : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (load) begin
            q <= w_seed_safe;
        end else begin
            q <= {q[14:0], w_feedback};
        end
    end

endmodule
`default_nettype wire

// File: rtl/rand_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : rand_arbiter
// Desc     : Round-robin arbiter handing out one LFSR word per grant, reduced
//            modulo the requester's bound by a 16-step shift-subtract.
// Revision : 1.0 - initial release
//==============================================================================
module rand_arbiter
    import rand_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*W-1:0]       bound,
    input  logic                       seed_we,
    input  logic [W-1:0]               seed,
    output logic [NUM_REQ-1:0]         ack,
    output logic [W-1:0]               rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(W);

    rand_state_t        r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [W-1:0]       r_value;
    logic [W-1:0]       r_bound;
    logic [W:0]         r_rem;
    logic [CW-1:0]      r_cnt;

    logic [W-1:0]       w_lfsr_q;
    logic [IDW-1:0]     w_winner;
    logic               w_found;
    logic [W-1:0]       w_win_bound;
    logic [W:0]         w_rem_shift;
    logic [W:0]         w_rem_next;
    logic [W-1:0]       w_result;
    logic [IDW-1:0]     w_rr_next;
    logic [NUM_REQ-1:0] w_onehot;

    lfsr16_core u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seed_we),
        .seed  (seed),
        .q     (w_lfsr_q)
    );

    // First active requester at or after the round-robin pointer
    always_comb begin
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(idx);
            end
        end
    end

    assign w_win_bound = bound[int'(w_winner)*W +: W];

    // Remainder stays below bound, so the shifted value always fits in W+1 bits
    assign w_rem_shift = {r_rem[W-1:0], r_value[r_cnt]};
    assign w_rem_next  = (w_rem_shift >= {1'b0, r_bound}) ? (w_rem_shift - {1'b0, r_bound})
                                                          : w_rem_shift;

    assign w_result  = (r_bound == '0) ? r_value : r_rem[W-1:0];
    assign w_rr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : (grant_id + 1'b1);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign w_onehot[gi] = (grant_id == IDW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_value  <= '0;
            r_bound  <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            ack      <= '0;
            rdata    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            ack <= '0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        grant_id <= w_winner;
                        r_value  <= w_lfsr_q;
                        r_bound  <= w_win_bound;
                        r_rem    <= '0;
                        r_cnt    <= CW'(W - 1);
                        busy     <= 1'b1;
                        r_state  <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (r_bound != '0) begin
                        r_rem <= w_rem_next;
                    end
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    rdata    <= w_result;
                    ack      <= w_onehot;
                    r_rr_ptr <= w_rr_next;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rand_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_rand_arbiter
// Desc     : Scoreboard bench for rand_arbiter with hand-computed LFSR results.
// Revision : 1.0 - initial release
//==============================================================================
module tb_rand_arbiter;

    localparam int NUM_REQ = 4;
    localparam int W       = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*W-1:0] bound;
    logic                 seed_we;
    logic [W-1:0]         seed;
    logic [NUM_REQ-1:0]   ack;
    logic [W-1:0]         rdata;
    logic [1:0]           grant_id;
    logic                 busy;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          gap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_ack = 0;
    int   want[NUM_REQ];

    rand_arbiter #(.NUM_REQ(NUM_REQ), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .bound    (bound),
        .seed_we  (seed_we),
        .seed     (seed),
        .ack      (ack),
        .rdata    (rdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic push(input int id, input logic [15:0] data, input int gap);
        exp_t e;
        e.id = id; e.data = data; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic set_bound(input int i, input logic [15:0] v);
        bound[i*W +: W] = v;
    endtask

    // Monitor: every ack pops one expected result
    always @(negedge clk) begin
        if (rst_n && ack != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: ack=%b rdata=0x%0h, expected no ack", ack, rdata);
            end else begin
                mon_e = sb.pop_front();
                check("ack_onehot", int'(ack), 1 << mon_e.id);
                check("grant_id", int'(grant_id), mon_e.id);
                check("rdata", int'(rdata), int'(mon_e.data));
                if (mon_e.gap > 0) check("ack_gap", cyc - last_ack, mon_e.gap);
            end
            last_ack = cyc;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req     = '0;
        bound   = '0;
        seed_we = 1'b0;
        seed    = '0;
        for (int i = 0; i < NUM_REQ; i++) want[i] = 0;
        repeat (3) @(negedge clk);
        check("reset_ack", int'(ack), 0);
        check("reset_rdata", int'(rdata), 0);
        check("reset_grant_id", int'(grant_id), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
    endtask

    // Requesters drop req in their ack cycle once their wanted draws are done
    task automatic wait_done();
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i]) begin
                    want[i]--;
                    if (want[i] <= 0) req[i] = 1'b0;
                end
            end
            if (sb.size() == 0 && !busy && ack == '0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_done_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        bound   = '0;
        seed_we = 1'b0;
        seed    = '0;
        for (int i = 0; i < NUM_REQ; i++) want[i] = 0;

        // Bound 0 returns the raw word; the second grant sees the LFSR 18 steps on
        do_reset();
        req[0] = 1'b1; set_bound(0, 16'h0000); want[0] = 2;
        push(0, 16'hFFFF, 0);
        push(0, 16'h3C27, 18);
        wait_done();

        // 65535 mod 10, then 0x3C27 mod 7 with the bound changed mid-flight
        do_reset();
        req[1] = 1'b1; set_bound(1, 16'd10); want[1] = 2;
        push(1, 16'd5, 0);
        push(1, 16'd6, 18);
        repeat (3) @(negedge clk);
        set_bound(1, 16'd7);
        wait_done();

        // Bound 1 gives 0; bound above the value returns it unchanged
        do_reset();
        req[1] = 1'b1; set_bound(1, 16'd1); want[1] = 2;
        push(1, 16'h0000, 0);
        push(1, 16'h3C27, 18);
        repeat (3) @(negedge clk);
        set_bound(1, 16'h4000);
        wait_done();

        // Bound 0xFFFF on 0xFFFF gives 0
        do_reset();
        req[1] = 1'b1; set_bound(1, 16'hFFFF); want[1] = 1;
        push(1, 16'h0000, 0);
        wait_done();

        // All requesters active: round-robin 0,1,2,3,0
        do_reset();
        set_bound(0, 16'd1); set_bound(1, 16'd0); set_bound(2, 16'd1); set_bound(3, 16'd1);
        req = 4'b1111;
        want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
        push(0, 16'h0000, 0);
        push(1, 16'h3C27, 18);
        push(2, 16'h0000, 18);
        push(3, 16'h0000, 18);
        push(0, 16'h0000, 18);
        wait_done();

        // Bound change and req drop during REDUCE are ignored
        do_reset();
        req[2] = 1'b1; set_bound(2, 16'd10); want[2] = 1;
        push(2, 16'd5, 0);
        repeat (4) @(negedge clk);
        check("busy_in_reduce", int'(busy), 1);
        req[2] = 1'b0;
        set_bound(2, 16'd3);
        wait_done();

        // Zero seed loads 0xFFFF
        do_reset();
        repeat (5) @(negedge clk);
        seed_we = 1'b1; seed = 16'h0000;
        @(negedge clk);
        seed_we = 1'b0;
        req[0] = 1'b1; set_bound(0, 16'h0000); want[0] = 1;
        push(0, 16'hFFFF, 0);
        wait_done();

        // Seed 1 steps to 2; a reseed mid-flight leaves the latched word alone
        seed_we = 1'b1; seed = 16'h0001;
        @(negedge clk);
        seed_we = 1'b0;
        @(negedge clk);
        req[0] = 1'b1; set_bound(0, 16'h0000); want[0] = 1;
        push(0, 16'h0002, 0);
        repeat (3) @(negedge clk);
        seed_we = 1'b1; seed = 16'h1234;
        @(negedge clk);
        seed_we = 1'b0;
        wait_done();

        // Reset mid-transaction aborts and clears the round-robin pointer
        do_reset();
        req[1] = 1'b1; set_bound(1, 16'h0000); want[1] = 1;
        push(1, 16'hFFFF, 0);
        wait_done();
        req[2] = 1'b1; set_bound(2, 16'h0000);
        repeat (9) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_rdata", int'(rdata), 0);
        check("abort_ack", int'(ack), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_bound(0, 16'd1); set_bound(2, 16'd1);
        req = 4'b0101;
        want[0] = 1; want[2] = 1;
        push(0, 16'h0000, 0);
        push(2, 16'h0000, 18);
        wait_done();

        repeat (25) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
